mdu_controller: RTL and testbench

MDU_CONTROLLER -- requirements
Module: mdu_controller

---
 rtl/mdu_controller_pkg.sv | 33 +++
 rtl/mdu_controller_cycle_counter.sv | 35 +++
 rtl/mdu_controller.sv | 128 ++++++++++++
 tb/tb_mdu_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mdu_controller_pkg.sv
// Shared constants and state encoding for the multiply/divide unit controller.
package mdu_controller_pkg;

    localparam int         CNT_W         = 6;
    localparam logic [6:0] OP_ADD        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_mdu_instr(input logic valid, input logic [6:0] opcode,
                                          input logic [6:0] funct7);
        return valid && (opcode == OP_ADD) && (funct7 == FUNCT7_MULDIV);
    endfunction

    // funct3[2] separates the divide/remainder group from the multiplies.
    function automatic logic is_div_class(input logic [2:0] funct3);
        return (funct3 & F3_DIV) != 3'b000;
    endfunction

endpackage

// File: rtl/mdu_controller_cycle_counter.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module mdu_cycle_counter
    import mdu_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mdu_controller.sv
// Multi-cycle MUL/DIV sequencer: launches the datapath, stalls IF/ID while it
// runs, and issues a one-cycle writeback pulse when the result is ready.
module mdu_controller
    import mdu_controller_pkg::*;
#(
    parameter int MUL_CYCLES  = 2,
    parameter int DIV_CYCLES  = 33,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic [6:0]             funct7,
    input  logic [RFIDX_WIDTH-1:0] rd,
    input  logic                   flush,
    output logic                   mdu_start,
    output logic [2:0]             mdu_op,
    output logic                   mdu_isdiv,
    output logic                   mdu_busy,
    output logic                   stall,
    output logic                   mdu_done,
    output logic [RFIDX_WIDTH-1:0] mdu_rd,
    output logic                   mdu_regwrite
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e             state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic                   isdiv_q, isdiv_d;
    logic [RFIDX_WIDTH-1:0] rd_q, rd_d;

    logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             is_m;

    assign is_m = is_mdu_instr(id_valid, opcode, funct7);

    mdu_cycle_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        isdiv_d      = isdiv_q;
        rd_d         = rd_q;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = is_div_class(funct3) ? DIV_LOAD : MUL_LOAD;
        mdu_start    = 1'b0;
        mdu_busy     = 1'b0;
        stall        = 1'b0;
        mdu_done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (is_m && !flush) begin
                    mdu_start = 1'b1;
                    stall     = 1'b1;
                    op_d      = funct3;
                    isdiv_d   = is_div_class(funct3);
                    rd_d      = rd;
                    cnt_load  = 1'b1;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                stall    = 1'b1;
                mdu_busy = 1'b1;
                if (cnt_zero)
                    state_d = S_DONE;
                else
                    cnt_dec = 1'b1;
            end
            S_DONE: begin
                // Result is written back now; drop the latched fields so
                // IDLE presents all-zero outputs.
                mdu_done = 1'b1;
                op_d     = '0;
                isdiv_d  = 1'b0;
                rd_d     = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            op_d     = '0;
            isdiv_d  = 1'b0;
            rd_d     = '0;
            cnt_clr  = 1'b1;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            isdiv_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            isdiv_q <= isdiv_d;
            rd_q    <= rd_d;
        end
    end

    assign mdu_op       = op_q;
    assign mdu_isdiv    = isdiv_q;
    assign mdu_rd       = rd_q;
    assign mdu_regwrite = mdu_done && (rd_q != '0);

endmodule

// File: tb/tb_mdu_controller.sv
// Scoreboard bench for mdu_controller: directed latency/flush/reset cases then
// randomized instruction streams against a cycle-window reference model.
module tb_mdu_controller;

    localparam int MUL_N = 2;
    localparam int DIV_N = 33;
    localparam int RW    = 5;
    localparam logic [6:0] OPC = 7'b0110011;
    localparam logic [6:0] F7M = 7'b0000001;

    logic          clk = 1'b0;
    logic          reset, id_valid, flush;
    logic [6:0]    opcode, funct7;
    logic [2:0]    funct3;
    logic [RW-1:0] rd;
    logic          mdu_start, mdu_isdiv, mdu_busy, stall, mdu_done, mdu_regwrite;
    logic [2:0]    mdu_op;
    logic [RW-1:0] mdu_rd;

    mdu_controller #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .RFIDX_WIDTH(RW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rd(rd), .flush(flush),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_isdiv(mdu_isdiv),
        .mdu_busy(mdu_busy), .stall(stall), .mdu_done(mdu_done),
        .mdu_rd(mdu_rd), .mdu_regwrite(mdu_regwrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [RW-1:0] rd;
    } done_t;

    done_t sb[$];
    done_t d;
    int    checks = 0, failures = 0, cyc = 0;
    bit    chk_en = 0;

    // Expected outputs for the current cycle, published by the driver.
    logic          e_start, e_stall, e_busy, e_done, e_isdiv;
    logic [2:0]    e_op;
    logic [RW-1:0] e_rd;

    // Reference model: one operation occupies cycles [t_s, t_s+n_s+1].
    bit            act = 0;
    int            t_s, n_s;
    logic [2:0]    m_op;
    logic          m_div;
    logic [RW-1:0] m_rd;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
        end
    endtask

    task automatic step(input logic v, input logic [6:0] opc, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [RW-1:0] r,
                        input logic fl, input logic rs);
        logic is_m;
        @(posedge clk);
        #1;
        cyc++;
        if (act && cyc > t_s + n_s + 1) act = 0;
        if (act && cyc == t_s + n_s + 1) begin
            fl = 1'b0;
            rs = 1'b0;
        end
        if (rs) v = 1'b0;
        id_valid = v; opcode = opc; funct7 = f7; funct3 = f3; rd = r;
        flush = fl; reset = rs;
        is_m = v && (opc == OPC) && (f7 == F7M);
        e_start = 0; e_stall = 0; e_busy = 0; e_done = 0;
        e_op = '0; e_isdiv = 0; e_rd = '0;
        if (!act && is_m && !fl) begin
            act   = 1;
            t_s   = cyc;
            m_div = f3[2];
            n_s   = m_div ? DIV_N : MUL_N;
            m_op  = f3;
            m_rd  = r;
            sb.push_back('{cyc + n_s + 1, r});
        end
        if (act) begin
            e_start = (cyc == t_s);
            e_stall = (cyc <= t_s + n_s);
            e_busy  = (cyc > t_s) && (cyc <= t_s + n_s);
            e_done  = (cyc == t_s + n_s + 1);
            if (cyc > t_s) begin
                e_op = m_op; e_isdiv = m_div; e_rd = m_rd;
            end
            if (fl || rs) begin
                act = 0;
                void'(sb.pop_back());
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 7'h0, 7'h0, 3'h0, '0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("start", mdu_start, e_start);
            chk("stall", stall, e_stall);
            chk("busy", mdu_busy, e_busy);
            chk("done", mdu_done, e_done);
            chk("op", mdu_op, e_op);
            chk("isdiv", mdu_isdiv, e_isdiv);
            chk("rd", mdu_rd, e_rd);
            chk("regwrite", mdu_regwrite, e_done && (e_rd != '0));
            if (mdu_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done cyc=%0d got=done exp=none", cyc);
                end else begin
                    d = sb.pop_front();
                    chk("done_cyc", cyc, d.cyc);
                    chk("done_rd", mdu_rd, d.rd);
                end
            end
        end
    end

    initial begin
        logic          v, fl, rs;
        logic [6:0]    opc, f7;
        logic [RW-1:0] r;
        reset = 1; id_valid = 0; flush = 0; opcode = '0; funct7 = '0; funct3 = '0; rd = '0;
        repeat (2) @(posedge clk);
        chk_en = 1;
        idle(2);

        step(1, OPC, F7M, 3'b000, 5'd5, 0, 0);          // MUL x5
        idle(4);
        step(1, OPC, F7M, 3'b101, 5'd7, 0, 0);          // DIVU x7
        idle(36);
        step(1, OPC, F7M, 3'b100, 5'd9, 0, 0);          // DIV, flushed at +10
        idle(9);
        step(0, 7'h0, 7'h0, 3'h0, '0, 1, 0);
        idle(3);
        step(1, OPC, F7M, 3'b000, 5'd0, 0, 0);          // MUL x0
        idle(4);
        step(1, OPC, F7M, 3'b000, 5'd3, 0, 0);          // MUL then MULH held in ID
        for (int i = 0; i < 4; i++) step(1, OPC, F7M, 3'b001, 5'd4, 0, 0);
        idle(4);
        step(1, OPC, F7M, 3'b100, 5'd6, 0, 0);          // DIV, reset at +5
        idle(4);
        step(0, 7'h0, 7'h0, 3'h0, '0, 0, 1);
        step(1, OPC, 7'h00, 3'b000, 5'd8, 0, 0);        // ADD must not start
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            opc = ($urandom_range(0, 7) != 0) ? OPC : 7'($urandom);
            f7  = ($urandom_range(0, 7) != 0) ? F7M : 7'($urandom);
            r   = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
            fl  = ($urandom_range(0, 39) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            step(v, opc, f7, 3'($urandom), r, fl, rs);
        end
        idle(40);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL pending_done got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
